// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin arbiter/sequencer sharing one signed 32x32 Booth
// multiplier among NREQ requesters.
//
// Ports
//   clk, reset                        clock; synchronous active-high reset
//   req_valid/req_ready               per-requester handshake; ready is a
//                                     one-hot grant pulse, only in IDLE
//   req_multiplicand/req_multiplier   packed 32-bit operands, requester i
//                                     at [32*i+31:32*i]
//   resp_valid/resp_ready             product handshake
//   resp_id/resp_result/resp_err      owner, signed 64-bit product, and a
//                                     timeout flag (result forced to 0)
//   busy                              high whenever not in IDLE
//   mul_op_start/mul_op_clear         multiplier control (never both high)
//   mul_multiplicand/mul_multiplier   registered operands to the multiplier
//   mul_op_done/mul_result            multiplier completion and product

// Per-requester grant slice. A requester wins if it is the lowest valid
// index at or above the pointer; with none at/above the pointer, the lowest
// valid index overall wins (wrap-around). The operands are zero-gated so the
// top can AND-OR them into a single mux.
module mul_arb_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic           grant_en,
  input  logic           valid,
  input  logic [IDW-1:0] ptr,
  input  logic           hi_below,   // some valid lane in [ptr, LANE)
  input  logic           any_below,  // some valid lane in [0, LANE)
  input  logic           any_hi,     // some valid lane in [ptr, NREQ)
  input  logic [31:0]    a_in,
  input  logic [31:0]    x_in,
  output logic           hi,
  output logic           ready,
  output logic [31:0]    a_out,
  output logic [31:0]    x_out
);
  assign hi    = valid && (ptr <= IDW'(LANE));
  assign ready = grant_en && (any_hi ? (hi && !hi_below) : (valid && !any_below));
  assign a_out = ready ? a_in : '0;
  assign x_out = ready ? x_in : '0;
endmodule

module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_multiplicand,
  input  logic [NREQ*32-1:0] req_multiplier,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [63:0]       resp_result,
  output logic              resp_err,
  output logic              busy,
  output logic              mul_op_start,
  output logic              mul_op_clear,
  output logic [31:0]       mul_multiplicand,
  output logic [31:0]       mul_multiplier,
  input  logic              mul_op_done,
  input  logic [63:0]       mul_result
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [63:0]    result;
    logic           err;
  } resp_t;

  state_t   state, state_nxt;
  resp_t    resp_q;
  logic [IDW-1:0] ptr, win_id, ptr_nxt;
  logic [CW-1:0]  run_cnt;
  logic [31:0]    op_a, op_x, sel_a, sel_x;
  logic           grant_en, run_done, run_tmo;

  logic [NREQ-1:0]           lane_hi, hi_below, any_below;
  logic                      any_hi, any_acc;
  logic [NREQ-1:0][31:0]     lane_a, lane_x;

  // Prefix ORs feeding the lanes; accumulators keep this a straight chain.
  always_comb begin
    hi_below  = '0;
    any_below = '0;
    any_hi    = 1'b0;
    any_acc   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hi_below[i]  = any_hi;
      any_below[i] = any_acc;
      any_hi       = any_hi  | lane_hi[i];
      any_acc      = any_acc | req_valid[i];
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    mul_arb_lane #(.IDW(IDW), .LANE(i)) u_lane (
      .grant_en  (grant_en),
      .valid     (req_valid[i]),
      .ptr       (ptr),
      .hi_below  (hi_below[i]),
      .any_below (any_below[i]),
      .any_hi    (any_hi),
      .a_in      (req_multiplicand[32*i +: 32]),
      .x_in      (req_multiplier[32*i +: 32]),
      .hi        (lane_hi[i]),
      .ready     (req_ready[i]),
      .a_out     (lane_a[i]),
      .x_out     (lane_x[i])
    );
  end

  // One-hot grant -> index and operand AND-OR mux.
  always_comb begin
    win_id = '0;
    sel_a  = '0;
    sel_x  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) win_id = IDW'(i);
      sel_a = sel_a | lane_a[i];
      sel_x = sel_x | lane_x[i];
    end
  end

  assign ptr_nxt = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Clear is held everywhere except LOAD/RUN so the multiplier's free-running
  // step count cannot raise op_done while we are not waiting for it.
  always_comb begin
    state_nxt    = state;
    grant_en     = 1'b0;
    mul_op_start = 1'b0;
    mul_op_clear = 1'b1;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    run_done     = 1'b0;
    run_tmo      = 1'b0;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        grant_en = 1'b1;
        if (|req_valid) state_nxt = LOAD;
      end
      LOAD: begin
        mul_op_start = 1'b1;
        mul_op_clear = 1'b0;
        state_nxt    = RUN;
      end
      RUN: begin
        mul_op_clear = 1'b0;
        // done wins over a timeout landing in the same cycle
        if (mul_op_done) begin
          run_done  = 1'b1;
          state_nxt = RESP;
        end else if (run_cnt == CW'(TIMEOUT - 1)) begin
          run_tmo   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      run_cnt <= '0;
      op_a    <= '0;
      op_x    <= '0;
      resp_q  <= '0;
    end else begin
      if (grant_en && |req_valid) begin
        op_a      <= sel_a;
        op_x      <= sel_x;
        resp_q.id <= win_id;
        ptr       <= ptr_nxt;
      end
      if (state == LOAD)     run_cnt <= '0;
      else if (state == RUN) run_cnt <= run_cnt + 1'b1;
      if (run_done) begin
        resp_q.result <= mul_result;
        resp_q.err    <= 1'b0;
      end else if (run_tmo) begin
        resp_q.result <= '0;
        resp_q.err    <= 1'b1;
      end
    end
  end

  assign resp_id          = resp_q.id;
  assign resp_result      = resp_q.result;
  assign resp_err         = resp_q.err;
  assign mul_multiplicand = op_a;
  assign mul_multiplier   = op_x;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a multiplier stand-in with programmable latency,
// a transaction-level reference model checked every cycle, directed cases
// with hand-computed literals, and a randomized phase.
module tb_mul_arbiter;
  localparam int NREQ = 4, IDW = 2, TIMEOUT = 64;

  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0, req_ready;
  logic [NREQ*32-1:0] req_multiplicand = '0, req_multiplier = '0;
  logic resp_valid, resp_ready = 1'b1, resp_err, busy;
  logic [IDW-1:0] resp_id;
  logic [63:0] resp_result, mul_result;
  logic mul_op_start, mul_op_clear, mul_op_done;
  logic [31:0] mul_multiplicand, mul_multiplier;

  mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_multiplicand(req_multiplicand), .req_multiplier(req_multiplier),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_err(resp_err), .busy(busy),
    .mul_op_start(mul_op_start), .mul_op_clear(mul_op_clear),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_op_done(mul_op_done), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: done mul_lat cycles after the start cycle;
  // result is garbage except while done is high.
  logic done_en = 1'b1;
  int   mul_lat = 34;
  int   mcnt = 0;
  always @(posedge clk) begin
    if (mul_op_clear)             mcnt <= 0;
    else if (mul_op_start)        mcnt <= 1;
    else if (mcnt != 0 && mcnt < 200) mcnt <= mcnt + 1;
  end
  assign mul_op_done = done_en && (mcnt == mul_lat);
  assign mul_result  = mul_op_done ?
      64'(longint'($signed(mul_multiplicand)) * longint'($signed(mul_multiplier))) :
      64'hDEAD_BEEF_0BAD_F00D;

  logic [NREQ-1:0] hs = '0;
  always @(posedge clk) hs <= req_valid & req_ready;

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: one transaction in flight, timeline relative to grant.
  bit     m_ok = 0, m_busy = 0, m_err = 0;
  int     m_g = 0, m_owner = 0, m_rt = 0, m_ptr = 0, cyc = 0;
  logic [31:0] m_a = '0, m_x = '0;
  longint m_prod = 0;

  always @(negedge clk) begin : cmp
    int w, t;
    logic [NREQ-1:0] er;
    logic erv, est, ecl;
    cyc++;
    w = -1;
    t = 0;
    if (!m_busy)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    erv = 1'b0; est = 1'b0; ecl = 1'b1;
    if (m_busy) begin
      t = cyc - m_g;
      if (t == 1)         begin est = 1'b1; ecl = 1'b0; end
      else if (t < m_rt)  ecl = 1'b0;
      else                erv = 1'b1;
    end
    if (m_ok) begin
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("op_start", 64'(mul_op_start), 64'(est));
      chk("op_clear", 64'(mul_op_clear), 64'(ecl));
      chk("resp_valid", 64'(resp_valid), 64'(erv));
      if (m_busy) begin
        chk("mul_a", 64'(mul_multiplicand), 64'(m_a));
        chk("mul_x", 64'(mul_multiplier), 64'(m_x));
      end
      if (erv) begin
        chk("resp_id", 64'(resp_id), 64'(m_owner));
        chk("resp_result", resp_result, m_err ? 64'd0 : 64'(m_prod));
        chk("resp_err", 64'(resp_err), 64'(m_err));
      end
    end
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_ok = 1;
    end else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_g = cyc; m_owner = w;
        m_a = req_multiplicand[32*w +: 32];
        m_x = req_multiplier[32*w +: 32];
        m_prod = longint'($signed(m_a)) * longint'($signed(m_x));
        if (done_en && mul_lat <= TIMEOUT) begin m_rt = mul_lat + 2; m_err = 0; end
        else                               begin m_rt = TIMEOUT + 2; m_err = 1; end
        m_ptr = (w + 1) % NREQ;
      end
    end else if (erv && resp_ready) begin
      m_busy = 0;
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req_valid = '0; resp_ready = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] x);
    req_valid[i] = 1'b1;
    req_multiplicand[32*i +: 32] = a;
    req_multiplier[32*i +: 32]   = x;
  endtask

  task automatic wait_grant(output int w);
    int n;
    n = 0; w = -1;
    while (w < 0 && n < 200) begin
      tick; n++;
      for (int i = 0; i < NREQ; i++) if (hs[i]) w = i;
    end
  endtask

  task automatic drain;
    int n;
    n = 0; req_valid = '0; resp_ready = 1'b1;
    while (busy && n < 200) begin tick; n++; end
    chk("drain_idle", 64'(busy), 64'd0);
  endtask

  // Single transaction from IDLE: grant cycle is 0, latency counted to the
  // first cycle resp_valid is seen.
  task automatic run_one(input string nm, input int i, input logic [31:0] a,
                         input logic [31:0] x, input int exp_lat,
                         input logic [63:0] exp_res, input logic exp_err);
    int n;
    bit seen;
    logic [NREQ-1:0] onehot;
    onehot = '0; onehot[i] = 1'b1;
    req_valid = '0; resp_ready = 1'b1;
    set_req(i, a, x);
    @(negedge clk);
    chk({nm, "_grant"}, 64'(req_ready), 64'(onehot));
    tick; req_valid[i] = 1'b0;
    @(negedge clk);
    chk({nm, "_start"}, 64'(mul_op_start), 64'd1);
    n = 1; seen = 0;
    while (!seen && n < 200) begin
      tick; n++;
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    if (seen) begin
      chk({nm, "_id"}, 64'(resp_id), 64'(i));
      chk({nm, "_result"}, resp_result, exp_res);
      chk({nm, "_err"}, 64'(resp_err), 64'(exp_err));
    end
    tick;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    int w;
    bit ok;
    int n;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_clear", 64'(mul_op_clear), 64'd1);
    chk("rst_start", 64'(mul_op_start), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_result", resp_result, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_mul_a", 64'(mul_multiplicand), 64'd0);
    tick;

    // basic latency and sign handling
    run_one("t1", 2, 32'd7, 32'hFFFF_FFFD, 36, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0);
    run_one("t6a", 0, 32'h8000_0000, 32'h8000_0000, 36, 64'h4000_0000_0000_0000, 1'b0);
    run_one("t6b", 1, 32'h0, 32'hFFFF_FFFF, 36, 64'h0, 1'b0);

    // timeout and done-vs-timeout boundary
    done_en = 1'b0;
    run_one("t4", 3, 32'd9, 32'd9, 66, 64'h0, 1'b1);
    done_en = 1'b1;
    mul_lat = TIMEOUT;
    run_one("tlast", 0, 32'd9, 32'd9, 66, 64'd81, 1'b0);
    mul_lat = TIMEOUT + 1;
    run_one("tlate", 1, 32'd9, 32'd9, 66, 64'h0, 1'b1);
    mul_lat = 34;

    // round-robin order, then wrap to 0 before 3
    do_reset;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'(i + 10));
    for (int k = 0; k < NREQ; k++) begin
      wait_grant(w);
      chk("t2_order", 64'(w), 64'(k));
    end
    req_valid = 4'b1001;
    wait_grant(w);
    chk("t2_wrap_first", 64'(w), 64'd0);
    wait_grant(w);
    chk("t2_wrap_second", 64'(w), 64'd3);
    drain;

    // back-pressure in RESP
    do_reset;
    set_req(1, 32'hFFFF_FFFB, 32'd100);
    wait_grant(w);
    req_valid = '0; resp_ready = 1'b0;
    ok = 0; n = 0;
    while (!ok && n < 200) begin
      tick; n++;
      @(negedge clk);
      if (resp_valid) ok = 1;
    end
    chk("t3_resp_seen", 64'(ok), 64'd1);
    tick;
    set_req(3, 32'd3, 32'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", 64'(resp_valid), 64'd1);
      chk("t3_hold_result", resp_result, 64'hFFFF_FFFF_FFFF_FE0C);
      chk("t3_hold_ready", 64'(req_ready), 64'd0);
      tick;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    tick;
    @(negedge clk);
    chk("t3_regrant", 64'(req_ready), 64'b1000);
    chk("t3_idle", 64'(busy), 64'd0);
    tick;
    drain;

    // reset in the middle of an operation
    do_reset;
    set_req(2, 32'd5, 32'd6);
    wait_grant(w);
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 20), 32'(i + 30));
    repeat (19) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_resp_valid", 64'(resp_valid), 64'd0);
    chk("t5_clear", 64'(mul_op_clear), 64'd1);
    chk("t5_resp_id", 64'(resp_id), 64'd0);
    chk("t5_resp_result", resp_result, 64'd0);
    chk("t5_mul_a", 64'(mul_multiplicand), 64'd0);
    chk("t5_grant0", 64'(req_ready), 64'b0001);
    tick;
    drain;

    // randomized traffic, latencies, back-pressure and resets
    for (int c = 0; c < 3000; c++) begin
      tick;
      if (!m_busy && $urandom_range(0, 9) == 0) begin
        mul_lat = ($urandom_range(0, 3) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 40);
        done_en = ($urandom_range(0, 9) != 0);
      end
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i]) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else set_req(i, rnd32(), rnd32());
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, rnd32(), rnd32());
        end
      end
      resp_ready = ($urandom_range(0, 2) != 0);
    end
    reset = 1'b0;
    done_en = 1'b1;
    mul_lat = 34;
    drain;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
